demux1_16_buf: RTL
==================

// Module: demux1_16_buf
// PURPOSE
//   Buffered 1-to-16 demultiplexer: routes one WIDTH-bit input word to one of 16 output lanes
//   chosen by a 4-bit select. Each lane holds its word until the lane's consumer takes it.
//   Distribution-side counterpart of the 16:1 select mux used in datapath/register-file paths.
//   Valid/ready handshake on the input port and on every output lane.
// PARAMETERS
//   WIDTH  8  data bits per word and per lane
//   CNT_W  8  width of the accepted-word counter
// PORTS
//   clk        in   1          single clock; all state updates on rising edge
//   reset_n    in   1          asynchronous, active-low reset
//   in_valid   in   1          input word present
//   in_sel     in   4          destination lane index, 0..15
//   in_data    in   WIDTH      input word
//   in_ready   out  1          input word accepted this cycle if in_valid is also 1
//   out_valid  out  16         out_valid[i]: lane i holds a word
//   out_data   out  16*WIDTH   lane i occupies bits [i*WIDTH +: WIDTH]
//   out_ready  in   16         out_ready[i]: consumer of lane i takes its word
//   acc_cnt    out  CNT_W      count of accepted input words
// BEHAVIOUR
//   - Reset (async assert, sync-safe deassert): full[15:0]=0, all lane data=0, acc_cnt=0.
//     While reset_n=0: out_valid=0 and in_ready=0. Mid-operation reset discards all held words at once.
//   - out_valid[i] = full[i]. out_data lane i = held register, stable while full[i]=1 and not popped.
//   - in_ready = reset_n & (~full[in_sel] | out_ready[in_sel]). This is combinational in in_sel and out_ready.
//   - accept = in_valid & in_ready. On accept: lane[in_sel] <= in_data, full[in_sel] <= 1.
//     Word is visible on out_data/out_valid the next cycle (latency 1).
//   - pop[i] = full[i] & out_ready[i]. It clears full[i] unless the same lane is written in the same cycle.
//     Simultaneous pop+write on one lane: full stays 1, the lane takes the new data.
//   - out_ready[i] has no effect while full[i]=0. in_data and in_sel are ignored when in_valid=0.
//   - Multiple lanes may pop in the same cycle, independently. There is one write per cycle at most.
//   - acc_cnt increments by 1 on each accept and wraps modulo 2^CNT_W (255 -> 0 at the default width).
//   - No state machine beyond the per-lane full flags. No lane ever drops or overwrites an unpopped word.
// CONFIGURATION
//   - Macro DEMUX_BROADCAST_EN.
//   - Defined: adds input port in_bcast (1 bit).
//     When in_bcast=1, in_sel is ignored and in_ready = reset_n & (all i: ~full[i] | out_ready[i]).
//     On accept, in_data is written to all 16 lanes, all full bits are set, and acc_cnt increments by 1.
//   - Undefined: the in_bcast port is absent and only single-lane writes exist.
// STRUCTURE
//   - Package demux16_pkg:
//     - NUM_LANES=16 and SEL_W=4.
//     - typedef logic [SEL_W-1:0] lane_sel_t.
//     - typedef logic [NUM_LANES-1:0] lane_mask_t.
//   - Sub-module dec4_16: 4-to-16 one-hot decoder with an enable input. It produces the lane write mask (wr_mask = en ? 1<<sel : 0).
//   - The top level holds 16 lane registers, the full flags, the in_ready logic and the counter.
// TESTING
//   1. reset_n=0 mid-stream with lanes full -> next sample: out_valid=16'h0000, in_ready=0, acc_cnt=0, all out_data=0.
//   2. in_sel=5, in_data=8'hA5, in_valid=1, out_ready=0 -> next cycle: out_valid=16'h0020, lane5=8'hA5, acc_cnt=1.
//   3. Lane 5 full, out_ready[5]=0, write sel=5 -> in_ready=0, lane unchanged.
//      Then out_ready[5]=1 with in_data=8'h5A -> accepted; lane5=8'h5A, out_valid[5] stays 1, acc_cnt=2.
//   4. Sweep in_sel 0..15 with data=sel*8'h11 and out_ready=0 -> out_valid=16'hFFFF, lane i=i*8'h11, acc_cnt=16.
//      Then out_ready=16'h00FF for 1 cycle -> out_valid=16'hFF00.
//   5. 256 accepts with CNT_W=8 -> acc_cnt wraps to 0. in_valid=0 cycles leave acc_cnt unchanged.
//   6. DEMUX_BROADCAST_EN cases:
//      - in_bcast=1, data=8'h3C, all lanes empty -> out_valid=16'hFFFF, every lane=8'h3C.
//      - Lane 2 full and out_ready[2]=0 -> in_ready=0, no lane changes.

Source files
------------

// File: rtl/demux1_16_buf_pkg.sv
// Shared lane-count constants and types for the buffered 1:16 demultiplexer.
package demux16_pkg;
    localparam int NUM_LANES = 16;
    localparam int SEL_W     = 4;

    typedef logic [SEL_W-1:0]     lane_sel_t;
    typedef logic [NUM_LANES-1:0] lane_mask_t;
endpackage

// File: rtl/demux1_16_buf_if.sv
// Producer/consumer bus of demux1_16_buf; in_bcast exists only when DEMUX_BROADCAST_EN is defined.
interface demux1_16_buf_if
    import demux16_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic                       in_valid;
    lane_sel_t                  in_sel;
    logic [WIDTH-1:0]           in_data;
    logic                       in_ready;
`ifdef DEMUX_BROADCAST_EN
    logic                       in_bcast;
`endif
    lane_mask_t                 out_valid;
    logic [NUM_LANES*WIDTH-1:0] out_data;
    lane_mask_t                 out_ready;
    logic [CNT_W-1:0]           acc_cnt;

`ifdef DEMUX_BROADCAST_EN
    modport master (output in_valid, in_sel, in_data, in_bcast, out_ready,
                    input  in_ready, out_valid, out_data, acc_cnt);
    modport slave  (input  in_valid, in_sel, in_data, in_bcast, out_ready,
                    output in_ready, out_valid, out_data, acc_cnt);
`else
    modport master (output in_valid, in_sel, in_data, out_ready,
                    input  in_ready, out_valid, out_data, acc_cnt);
    modport slave  (input  in_valid, in_sel, in_data, out_ready,
                    output in_ready, out_valid, out_data, acc_cnt);
`endif
endinterface

// File: rtl/demux1_16_buf_dec4_16.sv
// 4-to-16 one-hot decoder with enable; produces the per-lane write mask.
module dec4_16
    import demux16_pkg::*;
(
    input  logic       en_i,
    input  lane_sel_t  sel_i,
    output lane_mask_t mask_o
);
    assign mask_o = en_i ? (lane_mask_t'(1) << sel_i) : '0;
endmodule

// File: rtl/demux1_16_buf.sv
// Buffered 1:16 demux: one-word holding register per lane with valid/ready on input and lanes.
// Optional broadcast write to all lanes when DEMUX_BROADCAST_EN is defined.
module demux1_16_buf
    import demux16_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
)(
    input logic           clk,
    input logic           reset_n,
    demux1_16_buf_if.slave bus
);
    lane_mask_t                 full_q, full_d;
    logic [WIDTH-1:0]           lane_q [NUM_LANES];
    logic [CNT_W-1:0]           acc_cnt_q, acc_cnt_d;
    lane_mask_t                 free, pop, dec_mask, wr_mask;
    logic                       accept, bcast;
    logic [NUM_LANES*WIDTH-1:0] lane_flat;

`ifdef DEMUX_BROADCAST_EN
    assign bcast = bus.in_bcast;
`else
    assign bcast = 1'b0;
`endif

    // A lane can take a word if it is empty or is being drained this same cycle.
    assign free   = ~full_q | bus.out_ready;
    assign bus.in_ready = reset_n & (bcast ? (&free) : free[bus.in_sel]);
    assign accept = bus.in_valid & bus.in_ready;

    dec4_16 u_dec (
        .en_i   (accept & ~bcast),
        .sel_i  (bus.in_sel),
        .mask_o (dec_mask)
    );

    assign wr_mask   = (accept & bcast) ? '1 : dec_mask;
    assign pop       = full_q & bus.out_ready;
    assign full_d    = (full_q & ~pop) | wr_mask;
    assign acc_cnt_d = accept ? acc_cnt_q + CNT_W'(1) : acc_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full_q    <= '0;
            acc_cnt_q <= '0;
            for (int i = 0; i < NUM_LANES; i++) lane_q[i] <= '0;
        end else begin
            full_q    <= full_d;
            acc_cnt_q <= acc_cnt_d;
            for (int i = 0; i < NUM_LANES; i++)
                if (wr_mask[i]) lane_q[i] <= bus.in_data;
        end
    end

    always_comb begin
        lane_flat = '0;
        for (int i = 0; i < NUM_LANES; i++) lane_flat[i*WIDTH +: WIDTH] = lane_q[i];
    end

    assign bus.out_valid = full_q;
    assign bus.out_data  = lane_flat;
    assign bus.acc_cnt   = acc_cnt_q;
endmodule
